// File: rtl/bp_me_wb_pkg.sv
// rtl/bp_me_wb_pkg.sv - shared types and constants for the Wishbone RAM responder
package bp_me_wb_pkg;

    typedef enum logic [1:0] {
        e_idle   = 2'd0,
        e_wait   = 2'd1,
        e_access = 2'd2,
        e_resp   = 2'd3
    } bp_me_wb_resp_state_e;

    // Cycle-type codes kept here so burst support can be added later.
    localparam logic [2:0] e_wb_cti_classic = 3'b000;
    localparam logic [2:0] e_wb_cti_eob     = 3'b111;

endpackage

// File: rtl/bp_me_wb_ram_responder_if.sv
// rtl/bp_me_wb_ram_responder_if.sv - Wishbone B4 classic bus bundle
interface bp_me_wb_ram_responder_if #(
    parameter int data_width_p = 64,
    parameter int adr_width_p  = 27
);
    logic [adr_width_p-1:0]    adr_i;
    logic [data_width_p-1:0]   dat_i;
    logic                      cyc_i;
    logic                      stb_i;
    logic [data_width_p/8-1:0] sel_i;
    logic                      we_i;
    logic [2:0]                cti_i;
    logic [1:0]                bte_i;
    logic                      ack_o;
    logic                      err_o;
    logic [data_width_p-1:0]   dat_o;

    modport master (
        output adr_i, dat_i, cyc_i, stb_i, sel_i, we_i, cti_i, bte_i,
        input  ack_o, err_o, dat_o
    );

    modport slave (
        input  adr_i, dat_i, cyc_i, stb_i, sel_i, we_i, cti_i, bte_i,
        output ack_o, err_o, dat_o
    );
endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// rtl/bsg_mem_1rw_sync_mask_write_byte.sv - single-port synchronous RAM with byte write mask
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter  int width_p       = 64,
    parameter  int els_p         = 4096,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // One access per cycle: masked byte write or a read registered into data_o.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int i = 0; i < mask_width_lp; i++) begin
                if (write_mask_i[i]) begin
                    mem_r[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
                end
            end
        end
        if (v_i && !w_i) begin
            data_o <= mem_r[addr_i];
        end
    end

endmodule

// File: rtl/bp_me_wb_ram_responder.sv
// rtl/bp_me_wb_ram_responder.sv - Wishbone classic slave backed by a byte-masked on-chip RAM
module bp_me_wb_ram_responder
    import bp_me_wb_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int adr_width_p  = 27,
    parameter int els_p        = 4096,
    parameter int base_adr_p   = 0,
    parameter int latency_p    = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_me_wb_ram_responder_if.slave  wb
);

    localparam int idx_width_lp = $clog2(els_p);
    localparam int sel_width_lp = data_width_p / 8;

    // Range math is one bit wider so an address below the base wraps to a huge offset.
    localparam logic [adr_width_p:0] base_lp = (adr_width_p + 1)'(base_adr_p);
    localparam logic [adr_width_p:0] els_lp  = (adr_width_p + 1)'(els_p);
    localparam logic [3:0]           lat_lp  = 4'(latency_p);

    bp_me_wb_resp_state_e state_r, state_n;
    logic [3:0]              cnt_r, cnt_n;
    logic                    capture;
    logic                    ram_v;

    logic [adr_width_p-1:0]  adr_r;
    logic [data_width_p-1:0] dat_r;
    logic [sel_width_lp-1:0] sel_r;
    logic                    we_r;
    logic                    in_range_r;

    logic [adr_width_p:0]    req_off;
    logic                    req_in_range;
    logic [adr_width_p:0]    cap_off;
    logic [data_width_p-1:0] ram_data;

    assign req_off      = {1'b0, wb.adr_i} - base_lp;
    assign req_in_range = (req_off < els_lp);
    assign cap_off      = {1'b0, adr_r} - base_lp;

    // State and wait counter; reset always lands in idle.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Request fields are frozen at capture so later bus changes cannot leak in.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            adr_r      <= '0;
            dat_r      <= '0;
            sel_r      <= '0;
            we_r       <= 1'b0;
            in_range_r <= 1'b0;
        end else if (capture) begin
            adr_r      <= wb.adr_i;
            dat_r      <= wb.dat_i;
            sel_r      <= wb.sel_i;
            we_r       <= wb.we_i;
            in_range_r <= req_in_range;
        end
    end

    // Next-state logic: idle -> (wait) -> access -> resp -> idle, abort only while waiting.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        capture = 1'b0;
        ram_v   = 1'b0;
        case (state_r)
            e_idle: begin
                if (wb.cyc_i && wb.stb_i) begin
                    capture = 1'b1;
                    cnt_n   = lat_lp;
                    state_n = (lat_lp != 4'd0) ? e_wait : e_access;
                end
            end
            e_wait: begin
                if (!wb.cyc_i) begin
                    cnt_n   = '0;
                    state_n = e_idle;
                end else begin
                    cnt_n = cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_n = e_access;
                    end
                end
            end
            e_access: begin
                ram_v   = in_range_r;
                state_n = e_resp;
            end
            e_resp: begin
                state_n = e_idle;
            end
            default: begin
                state_n = e_idle;
            end
        endcase
    end

    bsg_mem_1rw_sync_mask_write_byte #(
        .width_p (data_width_p),
        .els_p   (els_p)
    ) ram (
        .clk_i        (clk_i),
        .v_i          (ram_v),
        .w_i          (we_r),
        .addr_i       (cap_off[idx_width_lp-1:0]),
        .data_i       (dat_r),
        .write_mask_i (sel_r),
        .data_o       (ram_data)
    );

    assign wb.ack_o = (state_r == e_resp) &&  in_range_r;
    assign wb.err_o = (state_r == e_resp) && !in_range_r;
    assign wb.dat_o = (wb.ack_o && !we_r) ? ram_data : '0;

    // Burst-type fields are accepted but every transfer is classic.
    logic unused_sigs;
    assign unused_sigs = ^{wb.cti_i, wb.bte_i, cap_off};

endmodule

// File: doc/bp_me_wb_ram_responder.md
# bp_me_wb_ram_responder

Wishbone B4 classic-cycle slave that services 64-bit requests from a Wishbone master with a synchronous on-chip RAM. It sits on the far end of the ibus/dbus Wishbone ports of the BlackParrot LiteX top and gives stand-alone simulation a memory target with no LiteX SoC. It supports programmable wait states, byte-masked writes, address-range error responses and cycle aborts.

## Interface
- data_width_p, 64: Wishbone data width; sel width is data_width_p/8.
- adr_width_p, 27: width of the word address.
- els_p, 4096: RAM depth in words.
- base_adr_p, 0: word address that maps to RAM entry 0.
- latency_p, 1: extra wait cycles before the access. Legal range is 0..15.
- clk_i  in  1  the single clock.
- reset_n_i  in  1  reset. Synchronous and active-low.
- adr_i  in  adr_width_p  word address.
- dat_i  in  data_width_p  write data.
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  strobe.
- sel_i  in  data_width_p/8  byte enables.
- we_i  in  1  1 = write, 0 = read.
- cti_i  in  3  cycle type. Ignored; every transfer is treated as classic.
- bte_i  in  2  burst type. Ignored.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- dat_o  out  data_width_p  read data.

## Operation
- FSM states are e_idle, e_wait, e_access and e_resp.
- **e_idle:**
  - A request is present when cyc_i & stb_i is 1.
  - On a request, capture adr_i, dat_i, sel_i and we_i into registers.
  - Compute in_range = (adr_i - base_adr_p) < els_p, using unsigned arithmetic at adr_width_p+1 bits.
  - Load the wait counter with latency_p.
  - Next state is e_wait if latency_p > 0, otherwise e_access.
- **e_wait:**
  - Decrement the counter each cycle.
  - Move to e_access when the counter reaches 1.
  - If cyc_i goes low here, abort: return to e_idle with no RAM access and no ack.
- **e_access:**
  - If in_range, issue exactly one RAM operation from the captured fields: index = captured adr - base_adr_p, with the write mask taken from the captured sel.
  - Writes commit at the end of this cycle. There is no abort check in this state.
  - Next state is e_resp.
- **e_resp:**
  - Assert ack_o if in_range, otherwise err_o, for exactly one cycle. ack_o and err_o are never both high.
  - dat_o = RAM read data for an in-range read. It is 0 for writes and for errors.
  - Next state is e_idle. The strobe is not re-sampled in this state.
- A write with sel = 0 completes with ack and leaves the RAM unchanged.
- Out of e_resp, dat_o is 0.
- The RAM is not initialised. Contents are X until written.

## Timing
- Reset values: ack_o = 0, err_o = 0, dat_o = 0, FSM in e_idle, counter = 0.
- Reset in any state returns to e_idle next cycle. A write in flight in e_wait is dropped. A write issued in e_access completes.
- Latency: request sampled in e_idle at cycle t gives ack_o/err_o in cycle t + latency_p + 2.
- Back-to-back throughput is one transfer per latency_p + 3 cycles. The master holding stb high after ack is re-sampled in e_idle as a new request.
- Inputs change only at request capture. Changes to dat_i, sel_i or adr_i after capture have no effect.
- If cyc_i drops in e_resp, the ack pulse is still driven. This is harmless to a compliant master.

## Structure
- A shared package, bp_me_wb_pkg, holds:
  - the state enum bp_me_wb_resp_state_e;
  - the cti constants e_wb_cti_classic = 3'b000 and e_wb_cti_eob = 3'b111, for future burst support.
- The RAM is one sub-module: bsg_mem_1rw_sync_mask_write_byte (width data_width_p, els_p, read latency 1).

## Test plan
- **Reset:** hold reset_n_i = 0 for 3 cycles while driving cyc/stb high -> no ack or err, dat_o = 0, stays idle.
- **Write then read:** latency_p = 1, base 0.
  - Write adr 5, data 64'h0123_4567_89AB_CDEF, sel 8'hFF -> ack in cycle t+3.
  - Read adr 5 -> dat_o = 64'h0123_4567_89AB_CDEF with ack.
- **Byte mask:** write 64'hFFFF_FFFF_FFFF_FFFF with sel 8'h0F over 0 -> read returns 64'h0000_0000_FFFF_FFFF.
- **Range error:**
  - Read adr els_p -> err_o for one cycle, ack_o = 0, dat_o = 0.
  - Read adr base_adr_p - 1 with base 16 -> err.
- **Abort:** latency_p = 4, start write to adr 2, drop cyc_i after 2 cycles -> no ack; adr 2 is unchanged on readback.
- **Back-to-back:** latency_p = 0, hold stb high for 4 reads -> acks every 3 cycles, each with the correct data; mid-stream change of adr_i after capture is ignored.
